// File: rtl/dfsm_layer_sequencer_pkg.sv
// Shared definitions for the DFSM layer sequencer and DFSM users: default sizing,
// derived config-word field widths, FSM state codes and a generic field extractor.
package dfsm_layer_sequencer_pkg;

  localparam int MAX_NPERIOD_DEF = 8;
  localparam int MAX_NLMAC_DEF   = 3 * 512 * 8;
  localparam int MAX_NSHFT_DEF   = 192;
  localparam int N_LAYERS_DEF    = 4;

  localparam int PW           = $clog2(MAX_NPERIOD_DEF);
  localparam int LW           = $clog2(MAX_NLMAC_DEF);
  localparam int SW           = $clog2(MAX_NSHFT_DEF);
  localparam int CONF_REG_LEN = PW + LW + SW;
  localparam int AW_DEF       = $clog2(N_LAYERS_DEF);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_NEXT  = 3'd4;
  localparam logic [2:0] ST_FIN   = 3'd5;

  // Width-generic so it works for any sizing of the nPeriod/nLMAC/nSHFT slices.
  function automatic logic [31:0] cfg_field(input logic [63:0] word, input int lsb,
                                            input int width);
    logic [63:0] sh;
    sh = (word >> lsb) & ((64'd1 << width) - 64'd1);
    return sh[31:0];
  endfunction

endpackage

// File: rtl/dfsm_layer_sequencer_if.sv
// Host-CSR and DFSM-facing signals of the layer sequencer; slave is the sequencer side.
interface dfsm_layer_sequencer_if
  import dfsm_layer_sequencer_pkg::*;
#(
  parameter int AW  = AW_DEF,
  parameter int LEN = CONF_REG_LEN
) ();

  logic           tbl_we;
  logic [AW-1:0]  tbl_addr;
  logic [LEN-1:0] tbl_wdata;
  logic [AW:0]    n_layers;
  logic           run;
  logic           period_done;
  logic           cfg_bit;
  logic           cfg_en;
  logic           dfsm_start;
  logic           busy;
  logic           done;
  logic [AW-1:0]  layer_idx;

  modport master (
    output tbl_we, tbl_addr, tbl_wdata, n_layers, run, period_done,
    input  cfg_bit, cfg_en, dfsm_start, busy, done, layer_idx
  );

  modport slave (
    input  tbl_we, tbl_addr, tbl_wdata, n_layers, run, period_done,
    output cfg_bit, cfg_en, dfsm_start, busy, done, layer_idx
  );

endinterface

// File: rtl/dfsm_layer_sequencer_cfg_serializer.sv
// Parallel-load PISO: load_i captures word_i, then LEN cycles of cfg_en_o with bits LSB first.
// One cycle from load_i to first bit; no backpressure, a new load_i restarts the shift.
module dfsm_layer_sequencer_cfg_serializer #(
  parameter int LEN = 25
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load_i,
  input  logic [LEN-1:0] word_i,
  output logic           cfg_bit_o,
  output logic           cfg_en_o,
  output logic           last_o
);

  localparam int CNTW = $clog2(LEN + 1);

  logic [LEN-1:0]  sh_q, sh_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            en_q, en_d;

  assign last_o    = en_q && (cnt_q == CNTW'(LEN - 1));
  assign cfg_bit_o = sh_q[0];
  assign cfg_en_o  = en_q;

  always_comb begin
    sh_d  = sh_q;
    cnt_d = cnt_q;
    en_d  = en_q;
    if (load_i) begin
      sh_d  = word_i;
      cnt_d = '0;
      en_d  = 1'b1;
    end else if (en_q) begin
      sh_d  = sh_q >> 1;
      cnt_d = cnt_q + CNTW'(1);
      if (last_o) en_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_q  <= '0;
      cnt_q <= '0;
      en_q  <= 1'b0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
      en_q  <= en_d;
    end
  end

endmodule

// File: rtl/dfsm_layer_sequencer.sv
// Steps one DFSM through a table of layer configs: serial load, start pulse, count periods.
// Outputs registered; run/table writes while busy are dropped, period_done outside WAIT ignored.
module dfsm_layer_sequencer
  import dfsm_layer_sequencer_pkg::*;
#(
  parameter int MAX_nPERIOD = MAX_NPERIOD_DEF,
  parameter int MAX_nLMAC   = MAX_NLMAC_DEF,
  parameter int MAX_nSHFT   = MAX_NSHFT_DEF,
  parameter int N_LAYERS    = N_LAYERS_DEF
) (
  input logic                  clk,
  input logic                  rst,
  dfsm_layer_sequencer_if.slave bus
);

  localparam int P_W   = $clog2(MAX_nPERIOD);
  localparam int L_W   = $clog2(MAX_nLMAC);
  localparam int S_W   = $clog2(MAX_nSHFT);
  localparam int C_LEN = P_W + L_W + S_W;
  localparam int A_W   = $clog2(N_LAYERS);
  localparam int CW    = P_W + 1;

  logic [C_LEN-1:0] tbl_q [N_LAYERS];
  logic [2:0]       state_q, state_d;
  logic [A_W-1:0]   layer_q, layer_d;
  logic [A_W:0]     nlay_q, nlay_d;
  logic [CW-1:0]    per_cnt_q, per_cnt_d;
  logic [CW-1:0]    np_eff_q, np_eff_d;
  logic             busy_q, done_q, start_q;

  logic             ser_load, ser_last, ser_bit, ser_en;
  logic [C_LEN-1:0] ser_word, cur_word;
  logic [A_W:0]     n_clamp;
  logic             np_is0;
  logic [CW-1:0]    np_val;

  assign cur_word = tbl_q[layer_q];
  assign np_is0   = (cfg_field(64'(cur_word), S_W + L_W, P_W) == 32'd0);
  assign np_val   = CW'(cfg_field(64'(cur_word), S_W + L_W, P_W));
  assign n_clamp  = (bus.n_layers > (A_W+1)'(N_LAYERS)) ? (A_W+1)'(N_LAYERS) : bus.n_layers;

  always_comb begin
    state_d   = state_q;
    layer_d   = layer_q;
    nlay_d    = nlay_q;
    per_cnt_d = per_cnt_q;
    np_eff_d  = np_eff_q;
    ser_load  = 1'b0;
    ser_word  = cur_word;
    case (state_q)
      ST_IDLE: begin
        if (bus.run) begin
          nlay_d  = n_clamp;
          layer_d = '0;
          if (n_clamp == '0) begin
            state_d = ST_FIN;
          end else begin
            state_d  = ST_LOAD;
            ser_load = 1'b1;
            ser_word = tbl_q[0];
          end
        end
      end
      ST_LOAD: if (ser_last) state_d = ST_START;
      ST_START: begin
        // A zero period count still runs one period so the DFSM always completes.
        np_eff_d  = np_is0 ? CW'(1) : np_val;
        per_cnt_d = '0;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.period_done) begin
          per_cnt_d = per_cnt_q + CW'(1);
          if ((per_cnt_q + CW'(1)) == np_eff_q) state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if ({1'b0, layer_q} == (nlay_q - (A_W+1)'(1))) begin
          state_d = ST_FIN;
        end else begin
          layer_d  = layer_q + A_W'(1);
          ser_word = tbl_q[layer_q + A_W'(1)];
          ser_load = 1'b1;
          state_d  = ST_LOAD;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_LAYERS; i++) tbl_q[i] <= '0;
    end else if (bus.tbl_we && !busy_q) begin
      tbl_q[bus.tbl_addr] <= bus.tbl_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      layer_q   <= '0;
      nlay_q    <= '0;
      per_cnt_q <= '0;
      np_eff_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      layer_q   <= layer_d;
      nlay_q    <= nlay_d;
      per_cnt_q <= per_cnt_d;
      np_eff_q  <= np_eff_d;
      busy_q    <= state_d inside {ST_LOAD, ST_START, ST_WAIT, ST_NEXT};
      done_q    <= (state_d == ST_FIN);
      start_q   <= (state_d == ST_START);
    end
  end

  dfsm_layer_sequencer_cfg_serializer #(
    .LEN (C_LEN)
  ) u_ser (
    .clk       (clk),
    .rst       (rst),
    .load_i    (ser_load),
    .word_i    (ser_word),
    .cfg_bit_o (ser_bit),
    .cfg_en_o  (ser_en),
    .last_o    (ser_last)
  );

  assign bus.cfg_bit    = ser_bit;
  assign bus.cfg_en     = ser_en;
  assign bus.dfsm_start = start_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.layer_idx  = layer_q;

endmodule

// File: tb/tb_dfsm_layer_sequencer.sv
// Randomized bench for dfsm_layer_sequencer with a DFSM-side protocol model and table scoreboard.
module tb_dfsm_layer_sequencer;

  localparam int LEN = 25;
  localparam int NL  = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dfsm_layer_sequencer_if bus ();

  dfsm_layer_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_err    = 0;
  int done_cnt = 0;
  int start_cnt = 0;
  int cfg_cnt  = 0;
  int overlap_cnt = 0;
  logic [LEN-1:0] tbl_m [NL];

  always @(negedge clk) begin
    if (bus.done) done_cnt++;
    if (bus.dfsm_start) start_cnt++;
    if (bus.cfg_en) cfg_cnt++;
    if (bus.done && bus.busy) overlap_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [LEN-1:0] mk_word(input int np, input int lm, input int sh);
    logic [2:0]  a;
    logic [13:0] b;
    logic [7:0]  c;
    a = np[2:0];
    b = lm[13:0];
    c = sh[7:0];
    return {a, b, c};
  endfunction

  task automatic tbl_write(input int a, input logic [LEN-1:0] d);
    bus.tbl_we    = 1'b1;
    bus.tbl_addr  = a[1:0];
    bus.tbl_wdata = d;
    tick();
    bus.tbl_we = 1'b0;
    tbl_m[a]   = d;
  endtask

  // Acts as the DFSM: captures the serial word, checks it at start, returns nP_eff out_en pulses.
  task automatic run_sequence(input int nl, input int gap_max, input bit noise, input bit tamper);
    int eff, d0, c0, s0, npe, gap;
    logic [LEN-1:0] cap;
    int nb;
    bit got;
    eff = (nl > NL) ? NL : nl;
    d0 = done_cnt;
    c0 = cfg_cnt;
    s0 = start_cnt;
    bus.n_layers = nl[2:0];
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    bus.n_layers = 3'($urandom_range(0, 7));
    if (eff == 0) begin
      check("zero_done", bus.done, 1);
      check("zero_busy", bus.busy, 0);
      tick();
      check("zero_done_clr", bus.done, 0);
      check("zero_no_cfg_en", cfg_cnt - c0, 0);
      check("zero_no_start", start_cnt - s0, 0);
      return;
    end
    check("run_busy", bus.busy, 1);
    for (int l = 0; l < eff; l++) begin
      cap = '0;
      nb  = 0;
      got = 1'b0;
      check("layer_idx", bus.layer_idx, l);
      for (int c = 0; c < LEN + 5; c++) begin
        if (bus.dfsm_start) begin
          got = 1'b1;
          break;
        end
        if (bus.cfg_en) begin
          cap = {bus.cfg_bit, cap[LEN-1:1]};
          nb++;
        end
        if (noise) bus.period_done = 1'($urandom_range(0, 1));
        tick();
      end
      check("start_seen", got, 1);
      check("cfg_bit_count", nb, LEN);
      check("cfg_word", cap, tbl_m[l]);
      check("start_cfg_en", bus.cfg_en, 0);
      if (noise) bus.period_done = 1'b1;
      tick();
      bus.period_done = 1'b0;
      check("start_one_cycle", bus.dfsm_start, 0);
      npe = (tbl_m[l] >> 22) & 7;
      if (npe == 0) npe = 1;
      for (int p = 0; p < npe; p++) begin
        gap = $urandom_range(0, gap_max);
        for (int g = 0; g < gap; g++) begin
          if (tamper && l == 0) begin
            bus.tbl_we    = 1'b1;
            bus.tbl_addr  = 2'd1;
            bus.tbl_wdata = 25'($urandom);
          end
          if (tamper) bus.run = 1'($urandom_range(0, 1));
          tick();
        end
        bus.tbl_we = 1'b0;
        bus.run    = 1'b0;
        check("wait_no_done", bus.done, 0);
        bus.period_done = 1'b1;
        tick();
        bus.period_done = 1'b0;
      end
      check("next_cfg_en", bus.cfg_en, 0);
      check("next_busy", bus.busy, 1);
      tick();
      if (l == eff - 1) begin
        check("fin_done", bus.done, 1);
        check("fin_busy", bus.busy, 0);
        tick();
        check("fin_done_clr", bus.done, 0);
      end
    end
    check("done_count", done_cnt - d0, 1);
  endtask

  initial begin
    bus.tbl_we = 1'b0;
    bus.tbl_addr = '0;
    bus.tbl_wdata = '0;
    bus.n_layers = '0;
    bus.run = 1'b0;
    bus.period_done = 1'b0;
    for (int i = 0; i < NL; i++) tbl_m[i] = '0;
    tick();
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_cfg_en", bus.cfg_en, 0);
    check("rst_cfg_bit", bus.cfg_bit, 0);
    check("rst_start", bus.dfsm_start, 0);
    check("rst_layer_idx", bus.layer_idx, 0);
    tick();
    rst = 1'b1;
    tick();

    tbl_write(0, mk_word(2, 4, 3));
    run_sequence(1, 2, 0, 0);

    tbl_write(0, mk_word(1, $urandom_range(0, 12287), $urandom_range(0, 191)));
    tbl_write(1, mk_word(3, $urandom_range(0, 12287), $urandom_range(0, 191)));
    tbl_write(2, mk_word(0, $urandom_range(0, 12287), $urandom_range(0, 191)));
    run_sequence(3, 3, 0, 0);

    run_sequence(0, 0, 0, 0);

    tbl_write(0, mk_word(3, 100, 17));
    tbl_write(1, mk_word(2, 7, 9));
    run_sequence(2, 4, 0, 1);

    run_sequence(3, 2, 1, 0);

    tbl_write(0, mk_word(1, 5, 6));
    tbl_write(1, mk_word(2, 1234, 77));
    bus.n_layers = 3'd2;
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (bus.dfsm_start) break;
      tick();
    end
    check("t5_start", bus.dfsm_start, 1);
    tick();
    bus.period_done = 1'b1;
    tick();
    bus.period_done = 1'b0;
    tick();
    repeat (10) tick();
    check("t5_pre_idx", bus.layer_idx, 1);
    check("t5_pre_cfg_en", bus.cfg_en, 1);
    #2 rst = 1'b0;
    #1;
    check("t5_busy", bus.busy, 0);
    check("t5_cfg_en", bus.cfg_en, 0);
    check("t5_cfg_bit", bus.cfg_bit, 0);
    check("t5_layer_idx", bus.layer_idx, 0);
    check("t5_done", bus.done, 0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < NL; i++) tbl_m[i] = '0;
    tick();
    check("t5_idle", bus.busy, 0);
    run_sequence(1, 2, 0, 0);

    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < NL; i++)
        tbl_write(i, mk_word($urandom_range(0, 7), $urandom_range(0, 12287),
                             $urandom_range(0, 191)));
      run_sequence($urandom_range(0, 7), 3, 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)));
    end

    tick();
    check("done_busy_overlap", overlap_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
